// File: rtl/order_msg_parser.sv
// order_msg_parser: streaming parser for three-word market/order messages.
// Words arrive over valid/ready. Framing is checked, fields are sliced into
// staging registers, and each good message is committed to a held output
// record presented over valid/ready.
// Optional build macro: MSG_STATS_EN adds saturating msg_count/err_count.
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high. A producer holds valid and its data stable until the
// transfer. The record outputs hold stable while out_valid && !out_ready.
module order_msg_parser #(
  parameter int REG_WIDTH = 32,
  parameter int SYMBOL_W  = 2,
  parameter int FUNC_W    = 3,
  parameter int QTY_W     = 8,
  parameter int PRICE_W   = 10,
  parameter int TIME_W    = 11,
  parameter int COUNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [REG_WIDTH-1:0]        in_data,
  input  logic                        in_valid,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [SYMBOL_W-1:0]         stock_symbol,
  output logic [FUNC_W-1:0]           trade_function,
  output logic [QTY_W-1:0]            quantity,
  output logic [PRICE_W-1:0]          current_price,
  output logic [REG_WIDTH-TIME_W-1:0] date_stamp,
  output logic [TIME_W-1:0]           time_stamp,
  output logic [PRICE_W-1:0]          buy_price,
  output logic [PRICE_W-1:0]          sell_price,
  output logic                        crossed,
  output logic                        frame_err
`ifdef MSG_STATS_EN
  ,
  output logic [COUNT_W-1:0]          msg_count,
  output logic [COUNT_W-1:0]          err_count
`endif
);

  localparam int DATE_W = REG_WIDTH - TIME_W;
  localparam int FUNC_HI  = REG_WIDTH - SYMBOL_W - 1;
  localparam int QTY_HI   = FUNC_HI - FUNC_W;
  localparam int PRICE_HI = QTY_HI - QTY_W;

  localparam logic [1:0] ST_W0      = 2'd0;
  localparam logic [1:0] ST_W1      = 2'd1;
  localparam logic [1:0] ST_W2      = 2'd2;
  localparam logic [1:0] ST_DISCARD = 2'd3;

  logic [1:0]          state;
  logic                hs;
  logic                commit;
  logic                err_now;
  logic                unused_bits;

  logic [SYMBOL_W-1:0] stg_symbol;
  logic [FUNC_W-1:0]   stg_func;
  logic [QTY_W-1:0]    stg_qty;
  logic [PRICE_W-1:0]  stg_price;
  logic [DATE_W-1:0]   stg_date;
  logic [TIME_W-1:0]   stg_time;

  // Word0 LSBs and word2 tail bits carry no fields.
  assign unused_bits = ^in_data;

  // Only the final word waits on the output slot; other words are always taken.
  always_comb begin
    in_ready = 1'b1;
    if (state == ST_W2) in_ready = !out_valid || out_ready;
  end

  assign hs      = in_valid && in_ready;
  assign commit  = hs && (state == ST_W2) && in_last;
  assign err_now = hs && ((((state == ST_W0) || (state == ST_W1)) && in_last) ||
                          ((state == ST_W2) && !in_last));

  // Word-position FSM with framing recovery.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_W0;
    end else if (hs) begin
      case (state)
        ST_W0:      state <= in_last ? ST_W0 : ST_W1;
        ST_W1:      state <= in_last ? ST_W0 : ST_W2;
        ST_W2:      state <= in_last ? ST_W0 : ST_DISCARD;
        default:    state <= in_last ? ST_W0 : ST_DISCARD;
      endcase
    end
  end

  // Staging registers for words 0 and 1; a bad frame is simply overwritten later.
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_symbol <= '0;
      stg_func   <= '0;
      stg_qty    <= '0;
      stg_price  <= '0;
      stg_date   <= '0;
      stg_time   <= '0;
    end else if (hs && (state == ST_W0)) begin
      stg_symbol <= in_data[REG_WIDTH-1 -: SYMBOL_W];
      stg_func   <= in_data[FUNC_HI -: FUNC_W];
      stg_qty    <= in_data[QTY_HI -: QTY_W];
      stg_price  <= in_data[PRICE_HI -: PRICE_W];
    end else if (hs && (state == ST_W1)) begin
      stg_date   <= in_data[REG_WIDTH-1 -: DATE_W];
      stg_time   <= in_data[TIME_W-1:0];
    end
  end

  // Output record: loads on commit, holds otherwise; valid drops on drain without commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      stock_symbol   <= '0;
      trade_function <= '0;
      quantity       <= '0;
      current_price  <= '0;
      date_stamp     <= '0;
      time_stamp     <= '0;
      buy_price      <= '0;
      sell_price     <= '0;
      crossed        <= 1'b0;
    end else if (commit) begin
      out_valid      <= 1'b1;
      stock_symbol   <= stg_symbol;
      trade_function <= stg_func;
      quantity       <= stg_qty;
      current_price  <= stg_price;
      date_stamp     <= stg_date;
      time_stamp     <= stg_time;
      buy_price      <= in_data[REG_WIDTH-1 -: PRICE_W];
      sell_price     <= in_data[REG_WIDTH-PRICE_W-1 -: PRICE_W];
      crossed        <= in_data[REG_WIDTH-1 -: PRICE_W] > in_data[REG_WIDTH-PRICE_W-1 -: PRICE_W];
    end else if (out_ready) begin
      out_valid      <= 1'b0;
    end
  end

  // Framing error pulse, one cycle after the offending handshake.
  always_ff @(posedge clk) begin
    if (rst) frame_err <= 1'b0;
    else     frame_err <= err_now;
  end

`ifdef MSG_STATS_EN
  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      msg_count <= '0;
      err_count <= '0;
    end else begin
      if (commit && (msg_count != '1)) msg_count <= msg_count + 1'b1;
      if (err_now && (err_count != '1)) err_count <= err_count + 1'b1;
    end
  end
`else
  localparam int unused_count_w = COUNT_W;
`endif

endmodule

// File: tb/tb_order_msg_parser.sv
// Bench for order_msg_parser: directed cases plus randomized messages,
// scored against a message-level reference model through an expected queue.
module tb_order_msg_parser;

  localparam int REG_WIDTH = 32;
  localparam int SYMBOL_W  = 2;
  localparam int FUNC_W    = 3;
  localparam int QTY_W     = 8;
  localparam int PRICE_W   = 10;
  localparam int TIME_W    = 11;
  localparam int COUNT_W   = 16;
  localparam int DATE_W    = REG_WIDTH - TIME_W;
  localparam int REC_W     = SYMBOL_W + FUNC_W + QTY_W + PRICE_W + DATE_W + TIME_W + 2*PRICE_W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [REG_WIDTH-1:0]  in_data = '0;
  logic                  in_valid = 1'b0;
  logic                  in_last = 1'b0;
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [SYMBOL_W-1:0]   stock_symbol;
  logic [FUNC_W-1:0]     trade_function;
  logic [QTY_W-1:0]      quantity;
  logic [PRICE_W-1:0]    current_price;
  logic [DATE_W-1:0]     date_stamp;
  logic [TIME_W-1:0]     time_stamp;
  logic [PRICE_W-1:0]    buy_price;
  logic [PRICE_W-1:0]    sell_price;
  logic                  crossed;
  logic                  frame_err;
`ifdef MSG_STATS_EN
  logic [COUNT_W-1:0]    msg_count;
  logic [COUNT_W-1:0]    err_count;
`endif

  order_msg_parser dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .stock_symbol(stock_symbol), .trade_function(trade_function), .quantity(quantity),
    .current_price(current_price), .date_stamp(date_stamp), .time_stamp(time_stamp),
    .buy_price(buy_price), .sell_price(sell_price), .crossed(crossed),
    .frame_err(frame_err)
`ifdef MSG_STATS_EN
    , .msg_count(msg_count), .err_count(err_count)
`endif
  );

  logic [REC_W-1:0] act_rec;
  assign act_rec = {stock_symbol, trade_function, quantity, current_price,
                    date_stamp, time_stamp, buy_price, sell_price, crossed};

  // ---------------- scoreboard state ----------------
  logic [REC_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int exp_err = 0;
  int seen_err = 0;
  bit rand_ready = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Field 'width' bits wide starting 'off' bits below the word MSB.
  function automatic longint unsigned fld(input logic [REG_WIDTH-1:0] w, input int off, input int width);
    longint unsigned v;
    v = longint'(w);
    return (v >> (REG_WIDTH - off - width)) % (64'd1 << width);
  endfunction

  function automatic logic [REC_W-1:0] model(input logic [REG_WIDTH-1:0] w0,
                                             input logic [REG_WIDTH-1:0] w1,
                                             input logic [REG_WIDTH-1:0] w2);
    logic [REC_W-1:0] r;
    longint unsigned buy, sell;
    buy  = fld(w2, 0, PRICE_W);
    sell = fld(w2, PRICE_W, PRICE_W);
    r = '0;
    r = (r << SYMBOL_W) | REC_W'(fld(w0, 0, SYMBOL_W));
    r = (r << FUNC_W)   | REC_W'(fld(w0, SYMBOL_W, FUNC_W));
    r = (r << QTY_W)    | REC_W'(fld(w0, SYMBOL_W + FUNC_W, QTY_W));
    r = (r << PRICE_W)  | REC_W'(fld(w0, SYMBOL_W + FUNC_W + QTY_W, PRICE_W));
    r = (r << DATE_W)   | REC_W'(fld(w1, 0, DATE_W));
    r = (r << TIME_W)   | REC_W'(fld(w1, DATE_W, TIME_W));
    r = (r << PRICE_W)  | REC_W'(buy);
    r = (r << PRICE_W)  | REC_W'(sell);
    r = (r << 1)        | REC_W'(buy > sell);
    return r;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (frame_err) seen_err++;
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            check("spurious_out_valid", 1, 0);
          end else begin
            check("record", act_rec, exp_q[0]);
            if (out_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // Random downstream backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [REG_WIDTH-1:0] d, input logic l);
    int waited;
    waited = 0;
    in_data = d;
    in_last = l;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 300) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  // A message of 'len' words with in_last on the final one.
  task automatic send_msg(input int len, input logic [REG_WIDTH-1:0] w0,
                          input logic [REG_WIDTH-1:0] w1, input logic [REG_WIDTH-1:0] w2,
                          input bit gaps);
    logic [REG_WIDTH-1:0] d;
    if (len == 3) exp_q.push_back(model(w0, w1, w2));
    else exp_err++;
    for (int i = 0; i < len; i++) begin
      d = (i == 0) ? w0 : (i == 1) ? w1 : (i == 2) ? w2 : REG_WIDTH'($urandom());
      send_word(d, i == len - 1);
      if (gaps && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    rand_ready = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_timeout", (exp_q.size() != 0) || out_valid, 0);
  endtask

  function automatic logic [REG_WIDTH-1:0] mk_w2(input int buy, input int sell);
    return (REG_WIDTH'(buy) << (REG_WIDTH - PRICE_W)) | (REG_WIDTH'(sell) << (REG_WIDTH - 2*PRICE_W));
  endfunction

  // ---------------- main sequence ----------------
  logic [REG_WIDTH-1:0] a0, a1, a2, b0, b1, b2;

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_record", act_rec, 0);
    @(posedge clk);
    #1;

    // Basic parse with known field values
    out_ready = 1'b1;
    send_msg(3, 32'h52ABE800, 32'h091A2AAB, 32'h4B136000, 0);
    @(negedge clk);
    check("basic_latency", out_valid, 1);
    check("basic_symbol", stock_symbol, 1);
    check("basic_func", trade_function, 2);
    check("basic_qty", quantity, 'h55);
    check("basic_price", current_price, 500);
    check("basic_date", date_stamp, 'h12345);
    check("basic_time", time_stamp, 'h2AB);
    check("basic_buy", buy_price, 300);
    check("basic_sell", sell_price, 310);
    check("basic_crossed", crossed, 0);
    drain();

    // Backpressure: hold first record, stage second, then drain+commit together
    out_ready = 1'b0;
    a0 = $urandom(); a1 = $urandom(); a2 = $urandom();
    b0 = $urandom(); b1 = $urandom(); b2 = $urandom();
    send_msg(3, a0, a1, a2, 0);
    exp_q.push_back(model(b0, b1, b2));
    send_word(b0, 0);
    send_word(b1, 0);
    in_data = b2;
    in_last = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready_low", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_on_drain", in_ready, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    @(negedge clk);
    check("bp_out_valid_continuous", out_valid, 1);
    check("bp_second_record", act_rec, model(b0, b1, b2));
    @(posedge clk);
    #1;
    drain();

    // Early last on word1
    send_msg(2, $urandom(), $urandom(), 0, 0);
    @(negedge clk);
    check("early_last_err_pulse", frame_err, 1);
    @(negedge clk);
    check("early_last_err_clear", frame_err, 0);
    @(posedge clk);
    #1;
    send_msg(3, $urandom(), $urandom(), $urandom(), 0);
    drain();
    check("early_last_err_count", seen_err, exp_err);

    // Missing last: five words, last on the fifth
    exp_err++;
    send_word($urandom(), 0);
    send_word($urandom(), 0);
    send_word($urandom(), 0);
    @(negedge clk);
    check("missing_last_err_pulse", frame_err, 1);
    @(posedge clk);
    #1;
    send_word($urandom(), 0);
    send_word($urandom(), 1);
    @(negedge clk);
    check("discard_no_err", frame_err, 0);
    @(posedge clk);
    #1;
    send_msg(3, $urandom(), $urandom(), $urandom(), 0);
    drain();
    check("missing_last_err_count", seen_err, exp_err);

    // Crossed comparator boundaries
    send_msg(3, $urandom(), $urandom(), mk_w2(311, 310), 0);
    @(negedge clk);
    check("crossed_311_310", crossed, 1);
    @(posedge clk);
    #1;
    send_msg(3, $urandom(), $urandom(), mk_w2(310, 310), 0);
    @(negedge clk);
    check("crossed_equal", crossed, 0);
    @(posedge clk);
    #1;
    drain();

    // Randomized traffic with random lengths, gaps and backpressure
    rand_ready = 1'b1;
    for (int m = 0; m < 60; m++) begin
      int len;
      int pick;
      pick = $urandom_range(0, 9);
      len = (pick < 7) ? 3 : (pick == 7) ? $urandom_range(1, 2) : $urandom_range(4, 5);
      send_msg(len, $urandom(), $urandom(), $urandom(), 1);
    end
    drain();
    check("random_err_count", seen_err, exp_err);

    // Mid-message reset, then one good message
    send_word($urandom(), 0);
    send_word($urandom(), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_msg(3, $urandom(), $urandom(), $urandom(), 0);
    drain();
`ifdef MSG_STATS_EN
    check("stats_msg_count", msg_count, 1);
    check("stats_err_count", err_count, 0);
`endif

    check("final_queue_empty", exp_q.size(), 0);
    check("final_err_count", seen_err, exp_err);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
